// File: rtl/sprite_line_fetcher.sv
// Scanline sprite row fetcher: during hblank, reads each visible sprite's next-line row
// from a shared ROM into a shadow buffer, then commits it to the renderers at end of line.
module sprite_line_fetcher #(
    parameter int NUM_SPRITES  = 4,
    parameter int SPRITE_SIZE  = 16,
    parameter int ROM_LATENCY  = 1,
    parameter int HBLANK_START = 640,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    localparam int SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [9:0]                        hpos,
    input  logic [9:0]                        vpos,
    input  logic [10*NUM_SPRITES-1:0]         sprite_y,
    input  logic [NUM_SPRITES-1:0]            sprite_frame,
    output logic                              rom_req,
    output logic [SW-1:0]                     rom_sprite,
    output logic                              rom_frame,
    output logic [3:0]                        rom_row,
    input  logic [SPRITE_SIZE-1:0]            rom_data,
    output logic [SPRITE_SIZE*NUM_SPRITES-1:0] row_bits,
    output logic [NUM_SPRITES-1:0]            row_valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int CW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY + 1) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] REQ   = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]             state;
    logic [SW-1:0]          idx;
    logic [9:0]             next_line;
    logic [CW-1:0]          cnt;
    logic [SPRITE_SIZE-1:0] shadow_bits [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] shadow_valid;

    logic [9:0]             sel_y;
    logic [9:0]             dy;
    logic                   sel_frame;
    logic                   hit;
    logic                   last;
    logic                   commit;
    logic                   trigger;
    logic [NUM_SPRITES-1:0] cut_mask;

    always_comb begin
        sel_y     = '0;
        sel_frame = 1'b0;
        cut_mask  = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (SW'(i) == idx) begin
                sel_y     = sprite_y[i*10 +: 10];
                sel_frame = sprite_frame[i];
            end
            // an unfinished sequence invalidates the current sprite and everything after it
            cut_mask[i] = busy && (SW'(i) >= idx);
        end
    end

    // modulo-1024 distance: sprites above the line wrap to large values and miss
    assign dy      = next_line - sel_y;
    assign hit     = dy < 10'(SPRITE_SIZE);
    assign last    = idx == SW'(NUM_SPRITES - 1);
    assign commit  = hpos == 10'(H_TOTAL - 1);
    assign trigger = (state == IDLE) && (hpos == 10'(HBLANK_START));
    assign busy    = (state == CHECK) || (state == REQ) || (state == WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            next_line    <= '0;
            cnt          <= '0;
            shadow_valid <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) shadow_bits[i] <= '0;
            rom_req      <= 1'b0;
            rom_sprite   <= '0;
            rom_frame    <= 1'b0;
            rom_row      <= '0;
            row_bits     <= '0;
            row_valid    <= '0;
            overrun      <= 1'b0;
        end else begin
            rom_req <= 1'b0;
            overrun <= 1'b0;
            if (commit) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    row_bits[i*SPRITE_SIZE +: SPRITE_SIZE] <= shadow_bits[i];
                    row_valid[i] <= shadow_valid[i] & ~cut_mask[i];
                end
                overrun <= busy;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: if (trigger) begin
                        next_line    <= (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
                        shadow_valid <= '0;
                        idx          <= '0;
                        state        <= CHECK;
                    end
                    CHECK: if (hit) begin
                        rom_req    <= 1'b1;
                        rom_sprite <= idx;
                        rom_row    <= dy[3:0];
                        rom_frame  <= sel_frame;
                        state      <= REQ;
                    end else begin
                        for (int i = 0; i < NUM_SPRITES; i++)
                            if (SW'(i) == idx) shadow_valid[i] <= 1'b0;
                        if (last) state <= DONE;
                        else      idx   <= idx + SW'(1);
                    end
                    REQ: begin
                        cnt   <= CW'(ROM_LATENCY);
                        state <= WAIT;
                    end
                    WAIT: if (cnt == CW'(1)) begin
                        for (int i = 0; i < NUM_SPRITES; i++) begin
                            if (SW'(i) == idx) begin
                                shadow_bits[i]  <= rom_data;
                                shadow_valid[i] <= 1'b1;
                            end
                        end
                        if (last) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + SW'(1);
                            state <= CHECK;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: default instance plus a short-line,
// slow-ROM instance that runs out of time and must report overrun.
module tb_sprite_line_fetcher;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  hpos = '0;
    logic [9:0]  vpos = '0;
    logic [39:0] sprite_y = '0;
    logic [3:0]  sprite_frame = '0;

    logic        rom_req, rom_frame, busy, overrun;
    logic [1:0]  rom_sprite;
    logic [3:0]  rom_row, row_valid;
    logic [15:0] rom_data = 16'h0BAD;
    logic [63:0] row_bits;

    logic        rom_req2, rom_frame2, busy2, overrun2;
    logic [1:0]  rom_sprite2;
    logic [3:0]  rom_row2, row_valid2;
    logic [15:0] rom_data2 = 16'h0BAD;
    logic [15:0] pipe2a = 16'h0BAD, pipe2b = 16'h0BAD;
    logic [63:0] row_bits2;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, busy_cnt = 0, req_cnt = 0, ovr_cnt = 0, ovr2_cnt = 0;
    int last_req = 0;
    bit have_last = 0;
    int gaps[$];
    logic [6:0] exp_q[$];

    sprite_line_fetcher dut (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
        .sprite_y(sprite_y), .sprite_frame(sprite_frame),
        .rom_req(rom_req), .rom_sprite(rom_sprite), .rom_frame(rom_frame),
        .rom_row(rom_row), .rom_data(rom_data), .row_bits(row_bits),
        .row_valid(row_valid), .busy(busy), .overrun(overrun)
    );

    sprite_line_fetcher #(.H_TOTAL(648), .ROM_LATENCY(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
        .sprite_y(sprite_y), .sprite_frame(sprite_frame),
        .rom_req(rom_req2), .rom_sprite(rom_sprite2), .rom_frame(rom_frame2),
        .rom_row(rom_row2), .rom_data(rom_data2), .row_bits(row_bits2),
        .row_valid(row_valid2), .busy(busy2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [1:0] s, input logic fr, input logic [3:0] r);
        return 16'hA5C3 ^ {r, 2'b00, s ^ 2'd2, 7'd0, fr};
    endfunction

    // ROM models: data is only meaningful exactly ROM_LATENCY cycles after the strobe
    always @(posedge clk) rom_data <= rom_req ? rom_word(rom_sprite, rom_frame, rom_row) : 16'h0BAD;
    always @(posedge clk) begin
        pipe2a    <= rom_req2 ? rom_word(rom_sprite2, rom_frame2, rom_row2) : 16'h0BAD;
        pipe2b    <= pipe2a;
        rom_data2 <= pipe2b;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [7:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (rom_req) begin
            if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
            else                  e = 8'hFF;
            chk("rom_addr", {56'd0, 1'b0, rom_sprite, rom_row, rom_frame}, {56'd0, e});
            req_cnt++;
            if (have_last) gaps.push_back(cyc - last_req);
            last_req  = cyc;
            have_last = 1;
        end
        busy_cnt += int'(busy);
        ovr_cnt  += int'(overrun);
        ovr2_cnt += int'(overrun2);
        hpos = hpos + 10'd1;
    endtask

    task automatic do_line(input bit retrig);
        logic [9:0] h;
        bit jumped = 0;
        busy_cnt = 0; req_cnt = 0; ovr_cnt = 0; ovr2_cnt = 0;
        gaps.delete();
        have_last = 0;
        hpos = 10'd638;
        do begin
            h = hpos;
            step();
            if (retrig && !jumped && hpos == 10'd642) begin
                hpos   = 10'd640;
                jumped = 1;
            end
        end while (h != 10'd799);
        hpos = 10'd0;
    endtask

    initial begin
        sprite_y = {4{10'd300}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_bits", row_bits, 64'd0);
        chk("rst_row_valid", {60'd0, row_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rom_req", {63'd0, rom_req}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        reset_n = 1'b1;

        // all sprites miss
        vpos = 10'd99;
        do_line(0);
        chk("t1_busy", busy_cnt, 4);
        chk("t1_reqs", req_cnt, 0);
        chk("t1_valid", {60'd0, row_valid}, 64'd0);
        chk("t1_ovr", ovr_cnt, 0);
        chk("t1_ovr2", ovr2_cnt, 0);

        // single hit on sprite 2
        sprite_y = {10'd300, 10'd100, 10'd300, 10'd300};
        sprite_frame = 4'b1011;
        exp_q.push_back({2'd2, 4'd0, 1'b0});
        do_line(0);
        chk("t2_reqs", req_cnt, 1);
        chk("t2_bits2", {48'd0, row_bits[47:32]}, 64'h0000_0000_0000_A5C3);
        chk("t2_valid", {60'd0, row_valid}, 64'b0100);
        chk("t2_busy", busy_cnt, 6);
        chk("t2_qleft", exp_q.size(), 0);

        // all four hit at dy=10; the slow instance runs out of line
        sprite_y = {4{10'd90}};
        sprite_frame = 4'b1010;
        exp_q.push_back({2'd0, 4'd10, 1'b0});
        exp_q.push_back({2'd1, 4'd10, 1'b1});
        exp_q.push_back({2'd2, 4'd10, 1'b0});
        exp_q.push_back({2'd3, 4'd10, 1'b1});
        do_line(0);
        chk("t3_reqs", req_cnt, 4);
        chk("t3_busy", busy_cnt, 12);
        chk("t3_valid", {60'd0, row_valid}, 64'b1111);
        chk("t3_ngaps", gaps.size(), 3);
        foreach (gaps[i]) chk("t3_gap", gaps[i], 3);
        chk("t3_bits0", {48'd0, row_bits[15:0]}, {48'd0, rom_word(2'd0, 1'b0, 4'd10)});
        chk("t3_bits3", {48'd0, row_bits[63:48]}, {48'd0, rom_word(2'd3, 1'b1, 4'd10)});
        chk("t3_ovr", ovr_cnt, 0);
        chk("t5_ovr2", ovr2_cnt, 1);
        chk("t5_valid2", {60'd0, row_valid2}, 64'b0001);
        chk("t5_bits2_0", {48'd0, row_bits2[15:0]}, {48'd0, rom_word(2'd0, 1'b0, 4'd10)});
        chk("t5_busy2", {63'd0, busy2}, 64'd0);

        // dy=16 on sprite 3 is a miss
        sprite_y = {10'd84, 10'd90, 10'd90, 10'd90};
        exp_q.push_back({2'd0, 4'd10, 1'b0});
        exp_q.push_back({2'd1, 4'd10, 1'b1});
        exp_q.push_back({2'd2, 4'd10, 1'b0});
        do_line(0);
        chk("t3b_reqs", req_cnt, 3);
        chk("t3b_valid", {60'd0, row_valid}, 64'b0111);
        chk("t3b_busy", busy_cnt, 10);

        // frame wrap: next_line 0, y=520 does not wrap around
        vpos = 10'd524;
        sprite_y = {10'd300, 10'd300, 10'd520, 10'd0};
        exp_q.push_back({2'd0, 4'd0, 1'b0});
        do_line(0);
        chk("t4_reqs", req_cnt, 1);
        chk("t4_valid", {60'd0, row_valid}, 64'b0001);
        chk("t4_bits0", {48'd0, row_bits[15:0]}, {48'd0, rom_word(2'd0, 1'b0, 4'd0)});
        chk("t4_busy", busy_cnt, 6);

        // asynchronous reset while waiting on the ROM
        vpos = 10'd99;
        sprite_y = {4{10'd90}};
        sprite_frame = 4'b0000;
        exp_q.push_back({2'd0, 4'd10, 1'b0});
        hpos = 10'd638;
        repeat (5) step();
        chk("t6_busy_pre", {63'd0, busy}, 64'd1);
        chk("t6_valid_pre", {60'd0, row_valid}, 64'b0001);
        chk("t6_qpre", exp_q.size(), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid_rst", {60'd0, row_valid}, 64'd0);
        chk("t6_bits_rst", row_bits, 64'd0);
        chk("t6_busy_rst", {63'd0, busy}, 64'd0);
        chk("t6_valid2_rst", {60'd0, row_valid2}, 64'd0);
        reset_n = 1'b1;

        // restart from sprite 0, with a second trigger while busy
        for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 4'd10, 1'b0});
        do_line(1);
        chk("t6_reqs", req_cnt, 4);
        chk("t6_busy", busy_cnt, 12);
        chk("t6_valid", {60'd0, row_valid}, 64'b1111);
        chk("t6_qleft", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
